// File: rtl/exe_stage_mdu_if.sv
// ID/EXE/MEM handshake, payload and bypass bundle for the EXE stage.
// The stage connects through the slave modport; its environment uses master.
interface exe_stage_mdu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                id_to_exe_valid;
    logic                exe_allow_in;
    logic                mem_allow_in;
    logic                exe_to_mem_valid;
    logic [31:0]         in_pc;
    logic [4:0]          in_op;
    logic [XLEN-1:0]     in_src1;
    logic [XLEN-1:0]     in_src2;
    logic [XLEN-1:0]     in_store_data;
    logic                in_reg_we;
    logic [4:0]          in_reg_waddr;
    logic                in_mem_en;
    logic                in_mem_store;
    logic [1:0]          in_mem_size;
    logic [31:0]         out_pc;
    logic [XLEN-1:0]     out_result;
    logic                out_res_from_mem;
    logic                out_reg_we;
    logic [4:0]          out_reg_waddr;
    logic [1:0]          out_mem_size;
    logic                out_ale;
    logic                data_sram_en;
    logic [XLEN/8-1:0]   data_sram_we;
    logic [ADDR_W-1:0]   data_sram_addr;
    logic [XLEN-1:0]     data_sram_wdata;
    logic                exe_valid;
    logic                exe_fwd_we;
    logic [4:0]          exe_fwd_waddr;
    logic [XLEN-1:0]     exe_fwd_data;
    logic                exe_fwd_busy;

    modport slave (
        input  id_to_exe_valid, mem_allow_in, in_pc, in_op, in_src1, in_src2, in_store_data,
               in_reg_we, in_reg_waddr, in_mem_en, in_mem_store, in_mem_size,
        output exe_allow_in, exe_to_mem_valid, out_pc, out_result, out_res_from_mem,
               out_reg_we, out_reg_waddr, out_mem_size, out_ale, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, exe_valid, exe_fwd_we, exe_fwd_waddr,
               exe_fwd_data, exe_fwd_busy
    );

    modport master (
        output id_to_exe_valid, mem_allow_in, in_pc, in_op, in_src1, in_src2, in_store_data,
               in_reg_we, in_reg_waddr, in_mem_en, in_mem_store, in_mem_size,
        input  exe_allow_in, exe_to_mem_valid, out_pc, out_result, out_res_from_mem,
               out_reg_we, out_reg_waddr, out_mem_size, out_ale, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, exe_valid, exe_fwd_we, exe_fwd_waddr,
               exe_fwd_data, exe_fwd_busy
    );
endinterface

// File: rtl/exe_stage_mdu.sv
// EXE pipeline stage: single-cycle ALU/multiplier, iterative restoring divider,
// store lane alignment with misalignment detection, and bypass/hazard outputs to ID.
module exe_stage_mdu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    exe_stage_mdu_if.slave bus
);
    localparam int unsigned Lanes = XLEN / 8;
    localparam int unsigned LaneW = $clog2(Lanes);
    localparam int unsigned ShW   = $clog2(XLEN);
    localparam int unsigned CntW  = $clog2(XLEN) + 1;

    localparam logic [4:0] OpAdd = 5'd0,  OpSub = 5'd1,   OpSlt = 5'd2,   OpSltu = 5'd3;
    localparam logic [4:0] OpAnd = 5'd4,  OpOr  = 5'd5,   OpXor = 5'd6,   OpNor  = 5'd7;
    localparam logic [4:0] OpSll = 5'd8,  OpSrl = 5'd9,   OpSra = 5'd10,  OpPass = 5'd11;
    localparam logic [4:0] OpMul = 5'd12, OpMulh = 5'd13, OpMulhu = 5'd14;
    localparam logic [4:0] OpDiv = 5'd15, OpDivu = 5'd16, OpMod = 5'd17,  OpModu = 5'd18;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    logic            valid_q;
    logic [31:0]     pc_q;
    logic [4:0]      op_q;
    logic [XLEN-1:0] src1_q, src2_q, store_data_q;
    logic            reg_we_q, mem_en_q, mem_store_q;
    logic [4:0]      reg_waddr_q;
    logic [1:0]      mem_size_q;

    logic ready_go, allow_in, is_div;

    div_state_e      div_state_q, div_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, divisor_q, divisor_d;
    logic            quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d, div_zero_q, div_zero_d;
    logic [XLEN:0]   rem_shift, rem_sub;
    logic            sign1, sign2;

    logic [XLEN-1:0]   sum, mul_hi_u, mul_hi_s, quot_res, rem_res, result;
    logic [2*XLEN-1:0] prod;
    logic [ShW-1:0]    shamt;

    logic             misalign, ale, mem_go;
    logic [Lanes-1:0] base_mask, mask;
    logic [XLEN-1:0]  wdata;
    logic [LaneW-1:0] offset;

    assign is_div   = (op_q >= OpDiv) && (op_q <= OpModu);
    assign ready_go = !is_div || (div_state_q == StDone);
    assign allow_in = !valid_q || (ready_go && bus.mem_allow_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (allow_in) begin
            valid_q <= bus.id_to_exe_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (allow_in && bus.id_to_exe_valid) begin
            pc_q         <= bus.in_pc;
            op_q         <= bus.in_op;
            src1_q       <= bus.in_src1;
            src2_q       <= bus.in_src2;
            store_data_q <= bus.in_store_data;
            reg_we_q     <= bus.in_reg_we;
            reg_waddr_q  <= bus.in_reg_waddr;
            mem_en_q     <= bus.in_mem_en;
            mem_store_q  <= bus.in_mem_store;
            mem_size_q   <= bus.in_mem_size;
        end
    end

    // One unsigned multiplier; the signed high half is corrected from the unsigned one.
    assign sum      = src1_q + src2_q;
    assign shamt    = src2_q[ShW-1:0];
    assign prod     = {{XLEN{1'b0}}, src1_q} * {{XLEN{1'b0}}, src2_q};
    assign mul_hi_u = prod[2*XLEN-1:XLEN];
    assign mul_hi_s = mul_hi_u - (src1_q[XLEN-1] ? src2_q : '0)
                               - (src2_q[XLEN-1] ? src1_q : '0);

    // Divider: the dividend magnitude shifts out of quot_q as quotient bits shift in.
    assign rem_shift = {rem_q, quot_q[XLEN-1]};
    assign rem_sub   = rem_shift - {1'b0, divisor_q};
    assign sign1     = ((op_q == OpDiv) || (op_q == OpMod)) && src1_q[XLEN-1];
    assign sign2     = ((op_q == OpDiv) || (op_q == OpMod)) && src2_q[XLEN-1];

    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        div_zero_d  = div_zero_q;
        case (div_state_q)
            StIdle: begin
                if (valid_q && is_div) begin
                    quot_d      = sign1 ? -src1_q : src1_q;
                    divisor_d   = sign2 ? -src2_q : src2_q;
                    rem_d       = '0;
                    cnt_d       = CntW'(XLEN);
                    quot_neg_d  = sign1 ^ sign2;
                    rem_neg_d   = sign1;
                    div_zero_d  = (src2_q == '0);
                    div_state_d = (src2_q == '0) ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (!rem_sub[XLEN]) begin
                    rem_d  = rem_sub[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    div_state_d = StDone;
                end
            end
            StDone: begin
                if (bus.mem_allow_in) begin
                    div_state_d = StIdle;
                end
            end
            default: div_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state_q <= StIdle;
            cnt_q       <= '0;
        end else begin
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        quot_q     <= quot_d;
        rem_q      <= rem_d;
        divisor_q  <= divisor_d;
        quot_neg_q <= quot_neg_d;
        rem_neg_q  <= rem_neg_d;
        div_zero_q <= div_zero_d;
    end

    assign quot_res = div_zero_q ? '1 : (quot_neg_q ? -quot_q : quot_q);
    assign rem_res  = div_zero_q ? src1_q : (rem_neg_q ? -rem_q : rem_q);

    always_comb begin
        result = '0;
        case (op_q)
            OpAdd:   result = sum;
            OpSub:   result = src1_q - src2_q;
            OpSlt:   result = XLEN'($signed(src1_q) < $signed(src2_q));
            OpSltu:  result = XLEN'(src1_q < src2_q);
            OpAnd:   result = src1_q & src2_q;
            OpOr:    result = src1_q | src2_q;
            OpXor:   result = src1_q ^ src2_q;
            OpNor:   result = ~(src1_q | src2_q);
            OpSll:   result = src1_q << shamt;
            OpSrl:   result = src1_q >> shamt;
            OpSra:   result = $unsigned($signed(src1_q) >>> shamt);
            OpPass:  result = src2_q;
            OpMul:   result = prod[XLEN-1:0];
            OpMulh:  result = mul_hi_s;
            OpMulhu: result = mul_hi_u;
            OpDiv, OpDivu: result = quot_res;
            OpMod, OpModu: result = rem_res;
            default: result = '0;
        endcase
    end

    assign offset = sum[LaneW-1:0];

    always_comb begin
        misalign  = 1'b0;
        base_mask = '0;
        wdata     = '0;
        case (mem_size_q)
            2'd0: begin
                base_mask = Lanes'(1);
                wdata     = {Lanes{store_data_q[7:0]}};
            end
            2'd1: begin
                misalign  = sum[0];
                base_mask = Lanes'(3);
                wdata     = {(Lanes/2){store_data_q[15:0]}};
            end
            2'd2: begin
                misalign  = |sum[1:0];
                base_mask = Lanes'(15);
                wdata     = {(XLEN/32){store_data_q[31:0]}};
            end
            default: begin
                misalign  = |sum[2:0];
                base_mask = '1;
                wdata     = store_data_q;
            end
        endcase
    end

    assign ale  = mem_en_q && misalign;
    assign mask = base_mask << offset;
    // The request fires only in the cycle the instruction advances, so MEM stalls never repeat it.
    assign mem_go = valid_q && mem_en_q && !ale && bus.mem_allow_in;

    assign bus.exe_allow_in     = allow_in;
    assign bus.exe_to_mem_valid = valid_q && ready_go;
    assign bus.exe_valid        = valid_q;
    assign bus.out_pc           = pc_q;
    assign bus.out_result       = result;
    assign bus.out_res_from_mem = mem_en_q && !mem_store_q;
    assign bus.out_reg_we       = reg_we_q;
    assign bus.out_reg_waddr    = reg_waddr_q;
    assign bus.out_mem_size     = mem_size_q;
    assign bus.out_ale          = ale;
    assign bus.data_sram_en     = mem_go;
    assign bus.data_sram_we     = (mem_go && mem_store_q) ? mask : '0;
    assign bus.data_sram_addr   = mem_go ? ADDR_W'(sum) : '0;
    assign bus.data_sram_wdata  = wdata;
    assign bus.exe_fwd_we       = valid_q && reg_we_q && !ale;
    assign bus.exe_fwd_waddr    = reg_waddr_q;
    assign bus.exe_fwd_data     = result;
    assign bus.exe_fwd_busy     = valid_q && reg_we_q && ((mem_en_q && !mem_store_q) || !ready_go);
endmodule
